// File: rtl/izh_neuron_ctrl.sv
// Configuration and run sequencer for one Izhikevich neuron core.
// Optional: define LOAD_TIMEOUT_EN to abort a stalled parameter load after 255 idle cycles.
module izh_neuron_ctrl #(
    parameter int unsigned TICK_DIV = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [7:0]       cfg_data,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    output logic [7:0]       param_a,
    output logic [7:0]       param_b,
    output logic [7:0]       param_c,
    output logic [7:0]       param_d,
    output logic             params_ready,
    output logic             neuron_reset,
    output logic             neuron_enable,
    input  logic             spike_in,
    output logic [CNT_W-1:0] spike_count,
    output logic             running
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    logic [1:0]       r_state, w_state_d;
    logic [1:0]       r_idx, w_idx_d;
    logic [7:0]       r_sh_a, r_sh_b, r_sh_c;
    logic [7:0]       w_sh_a_d, w_sh_b_d, w_sh_c_d;
    logic [PW-1:0]    r_presc, w_presc_d;
    logic [CNT_W-1:0] w_count_d;
    logic             w_accept, w_commit, w_timeout, w_enable_d;

    assign w_accept = cfg_valid & cfg_ready;

`ifdef LOAD_TIMEOUT_EN
    logic [7:0] r_idle_cnt;

    // Fires on the 255th consecutive LOAD cycle without an accepted byte.
    assign w_timeout = (r_state == ST_LOAD) && !w_accept && (r_idle_cnt == 8'd254);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= 8'd0;
        end else if ((r_state != ST_LOAD) || w_accept || w_timeout) begin
            r_idle_cnt <= 8'd0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_sh_a_d  = r_sh_a;
        w_sh_b_d  = r_sh_b;
        w_sh_c_d  = r_sh_c;
        w_presc_d = r_presc;
        w_count_d = spike_count;
        w_commit  = 1'b0;
        case (r_state)
            ST_IDLE, ST_ARMED: begin
                if ((r_state == ST_ARMED) && start) begin
                    w_state_d = ST_RUN;
                    w_presc_d = '0;
                    w_count_d = '0;
                end else if (w_accept) begin
                    w_sh_a_d  = cfg_data;
                    w_idx_d   = 2'd1;
                    w_state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    case (r_idx)
                        2'd1:    w_sh_b_d = cfg_data;
                        2'd2:    w_sh_c_d = cfg_data;
                        default: begin
                            w_commit  = 1'b1;
                            w_state_d = ST_ARMED;
                        end
                    endcase
                    w_idx_d = r_idx + 2'd1;
                end else if (w_timeout) begin
                    w_idx_d   = 2'd0;
                    w_sh_a_d  = 8'd0;
                    w_sh_b_d  = 8'd0;
                    w_sh_c_d  = 8'd0;
                    w_state_d = params_ready ? ST_ARMED : ST_IDLE;
                end
            end
            default: begin
                if (spike_in && (spike_count != CNT_MAX)) begin
                    w_count_d = spike_count + 1'b1;
                end
                if (stop) begin
                    w_state_d = ST_ARMED;
                    w_presc_d = '0;
                end else begin
                    w_presc_d = (r_presc == TERM) ? '0 : r_presc + PW'(1);
                end
            end
        endcase
        // Registered tick lands in the cycle where the prescaler sits at terminal count.
        w_enable_d = (w_state_d == ST_RUN) && (w_presc_d == TERM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= 2'd0;
            r_sh_a        <= 8'd0;
            r_sh_b        <= 8'd0;
            r_sh_c        <= 8'd0;
            r_presc       <= '0;
            param_a       <= 8'h02;
            param_b       <= 8'h33;
            param_c       <= 8'h80;
            param_d       <= 8'h80;
            params_ready  <= 1'b0;
            neuron_reset  <= 1'b1;
            neuron_enable <= 1'b0;
            spike_count   <= '0;
            running       <= 1'b0;
            cfg_ready     <= 1'b1;
        end else begin
            r_state       <= w_state_d;
            r_idx         <= w_idx_d;
            r_sh_a        <= w_sh_a_d;
            r_sh_b        <= w_sh_b_d;
            r_sh_c        <= w_sh_c_d;
            r_presc       <= w_presc_d;
            spike_count   <= w_count_d;
            neuron_enable <= w_enable_d;
            neuron_reset  <= (w_state_d != ST_RUN);
            running       <= (w_state_d == ST_RUN);
            cfg_ready     <= (w_state_d != ST_RUN);
            if (w_commit) begin
                param_a      <= r_sh_a;
                param_b      <= r_sh_b;
                param_c      <= r_sh_c;
                param_d      <= cfg_data;
                params_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_izh_neuron_ctrl.sv
// Directed self-checking bench for izh_neuron_ctrl (TICK_DIV=16, CNT_W=8).
module tb_izh_neuron_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'd0;
    logic       cfg_ready;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] param_a, param_b, param_c, param_d;
    logic       params_ready, neuron_reset, neuron_enable, running;
    logic       spike_in = 1'b0;
    logic [7:0] spike_count;

    int n_checks = 0;
    int n_fail = 0;

    izh_neuron_ctrl #(.TICK_DIV(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .start(start), .stop(stop), .param_a(param_a),
        .param_b(param_b), .param_c(param_c), .param_d(param_d),
        .params_ready(params_ready), .neuron_reset(neuron_reset),
        .neuron_enable(neuron_enable), .spike_in(spike_in), .spike_count(spike_count),
        .running(running)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        cfg_valid = 1'b1;
        cfg_data  = b;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({param_a, param_b, param_c, param_d} !== 32'h02338080) begin
            $display("FAIL reset_params got=%h want=02338080", {param_a, param_b, param_c, param_d});
            n_fail++;
        end
        n_checks++;
        if ({params_ready, neuron_reset, neuron_enable, running, cfg_ready} !== 5'b01001) begin
            $display("FAIL reset_flags got=%b want=01001",
                     {params_ready, neuron_reset, neuron_enable, running, cfg_ready});
            n_fail++;
        end
        n_checks++;
        if (spike_count !== 8'd0) begin
            $display("FAIL reset_count got=%0d want=0", spike_count);
            n_fail++;
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        logic [7:0] b [4] = '{8'h02, 8'h33, 8'h80, 8'h80};
        for (int i = 0; i < 4; i++) begin
            send(b[i]);
            n_checks++;
            if (params_ready !== (i == 3) || cfg_ready !== 1'b1) begin
                $display("FAIL load_byte%0d ready got=%b/%b want=%b/1", i, params_ready,
                         cfg_ready, (i == 3));
                n_fail++;
            end
        end
        n_checks++;
        if ({param_a, param_b, param_c, param_d} !== 32'h02338080) begin
            $display("FAIL load_params got=%h want=02338080", {param_a, param_b, param_c, param_d});
            n_fail++;
        end
    endtask

    task automatic test_reload();
        logic [7:0] b [4] = '{8'h05, 8'h40, 8'h60, 8'h90};
        for (int i = 0; i < 4; i++) begin
            send(b[i]);
            n_checks++;
            if ({param_a, param_b, param_c, param_d} !== ((i == 3) ? 32'h05406090 : 32'h02338080)
                || params_ready !== 1'b1) begin
                $display("FAIL reload_byte%0d got=%h rdy=%b want=%h rdy=1", i,
                         {param_a, param_b, param_c, param_d}, params_ready,
                         ((i == 3) ? 32'h05406090 : 32'h02338080));
                n_fail++;
            end
        end
    endtask

    task automatic test_run_ticks();
        int pulses = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({running, neuron_reset, cfg_ready, neuron_enable} !== 4'b1000) begin
            $display("FAIL run_entry got=%b want=1000",
                     {running, neuron_reset, cfg_ready, neuron_enable});
            n_fail++;
        end
        cfg_valid = 1'b1;
        cfg_data  = 8'hEE;
        for (int c = 2; c <= 63; c++) begin
            step();
            if (neuron_enable) pulses++;
            n_checks++;
            if (neuron_enable !== ((c % 16) == 0)) begin
                $display("FAIL run_tick cycle=%0d got=%b want=%b", c, neuron_enable,
                         ((c % 16) == 0));
                n_fail++;
            end
        end
        cfg_valid = 1'b0;
        n_checks++;
        if (pulses != 3 || cfg_ready !== 1'b0 ||
            {param_a, param_b, param_c, param_d} !== 32'h05406090) begin
            $display("FAIL run_cfg_ignored pulses=%0d rdy=%b params=%h want 3/0/05406090",
                     pulses, cfg_ready, {param_a, param_b, param_c, param_d});
            n_fail++;
        end
        // Prescaler is one short of terminal count here; stop must suppress the tick.
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if ({neuron_enable, running, neuron_reset, cfg_ready, params_ready} !== 5'b00111
            || spike_count !== 8'd0) begin
            $display("FAIL run_stop got=%b cnt=%0d want=00111 cnt=0",
                     {neuron_enable, running, neuron_reset, cfg_ready, params_ready}, spike_count);
            n_fail++;
        end
    endtask

    task automatic test_saturate();
        start = 1'b1;
        step();
        start = 1'b0;
        spike_in = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 10) begin
                n_checks++;
                if (spike_count !== 8'd10) begin
                    $display("FAIL sat_partial got=%0d want=10", spike_count);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (spike_count !== 8'd255) begin
            $display("FAIL sat_max got=%0d want=255", spike_count);
            n_fail++;
        end
        spike_in = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        spike_in = 1'b1;
        step();
        step();
        spike_in = 1'b0;
        n_checks++;
        if (spike_count !== 8'd255 || running !== 1'b0) begin
            $display("FAIL sat_hold got=%0d run=%b want=255 run=0", spike_count, running);
            n_fail++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (spike_count !== 8'd0 || running !== 1'b1) begin
            $display("FAIL sat_restart got=%0d run=%b want=0 run=1", spike_count, running);
            n_fail++;
        end
        for (int c = 2; c <= 17; c++) begin
            step();
            n_checks++;
            if (neuron_enable !== (c == 16)) begin
                $display("FAIL restart_tick cycle=%0d got=%b want=%b", c, neuron_enable, (c == 16));
                n_fail++;
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_start_stop_together();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if (running !== 1'b1 || neuron_reset !== 1'b0) begin
            $display("FAIL start_wins run=%b nrst=%b want run=1 nrst=0", running, neuron_reset);
            n_fail++;
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_ignored_start();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({running, neuron_reset, cfg_ready, params_ready} !== 4'b0110) begin
            $display("FAIL idle_start got=%b want=0110",
                     {running, neuron_reset, cfg_ready, params_ready});
            n_fail++;
        end
        send(8'h11);
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (running !== 1'b0 || cfg_ready !== 1'b1) begin
            $display("FAIL load_start run=%b rdy=%b want run=0 rdy=1", running, cfg_ready);
            n_fail++;
        end
        send(8'h22);
        send(8'h33);
        send(8'h44);
        n_checks++;
        if ({param_a, param_b, param_c, param_d} !== 32'h11223344 || params_ready !== 1'b1) begin
            $display("FAIL load_after_start got=%h rdy=%b want=11223344 rdy=1",
                     {param_a, param_b, param_c, param_d}, params_ready);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        send(8'hAA);
        send(8'hBB);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({param_a, param_b, param_c, param_d} !== 32'h02338080 || params_ready !== 1'b0
            || cfg_ready !== 1'b1) begin
            $display("FAIL areset_load got=%h rdy=%b cr=%b want=02338080 rdy=0 cr=1",
                     {param_a, param_b, param_c, param_d}, params_ready, cfg_ready);
            n_fail++;
        end
        rst_n = 1'b1;
        step();
        send(8'hCC);
        send(8'hDD);
        send(8'hEE);
        send(8'hFF);
        n_checks++;
        if ({param_a, param_b, param_c, param_d} !== 32'hCCDDEEFF) begin
            $display("FAIL areset_reload got=%h want=ccddeeff", {param_a, param_b, param_c, param_d});
            n_fail++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        spike_in = 1'b1;
        step();
        step();
        step();
        spike_in = 1'b0;
        n_checks++;
        if (spike_count !== 8'd3) begin
            $display("FAIL areset_run_cnt got=%0d want=3", spike_count);
            n_fail++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({running, neuron_reset, neuron_enable, params_ready} !== 4'b0100
            || spike_count !== 8'd0) begin
            $display("FAIL areset_run got=%b cnt=%0d want=0100 cnt=0",
                     {running, neuron_reset, neuron_enable, params_ready}, spike_count);
            n_fail++;
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_stall();
        send(8'h01);
        send(8'h02);
        for (int k = 0; k < 300; k++) step();
`ifdef LOAD_TIMEOUT_EN
        n_checks++;
        if (params_ready !== 1'b0 || cfg_ready !== 1'b1) begin
            $display("FAIL timeout_idle rdy=%b cr=%b want rdy=0 cr=1", params_ready, cfg_ready);
            n_fail++;
        end
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        send(8'hA4);
        n_checks++;
        if ({param_a, param_b, param_c, param_d} !== 32'hA1A2A3A4) begin
            $display("FAIL timeout_reload got=%h want=a1a2a3a4", {param_a, param_b, param_c, param_d});
            n_fail++;
        end
`else
        send(8'hA3);
        send(8'hA4);
        n_checks++;
        if ({param_a, param_b, param_c, param_d} !== 32'h0102A3A4 || params_ready !== 1'b1) begin
            $display("FAIL stall_resume got=%h rdy=%b want=0102a3a4 rdy=1",
                     {param_a, param_b, param_c, param_d}, params_ready);
            n_fail++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_reload();
        test_run_ticks();
        test_saturate();
        test_start_stop_together();
        test_ignored_start();
        test_async_reset();
        test_load_stall();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
